axi_wr_sched: RTL

- Transaction-level scheduler that shares one downstream AXI write channel (AW/W/B) between S_COUNT upstream masters.
- Selects one master by round robin and forwards its AW beat.
- Routes that master's W beats until WLAST, then returns the single B response to it before re-arbitrating.
- Sits between the masters and a shared slave port in the interconnect; payloads are opaque vectors.

---
 rtl/axi_sched_pkg.sv | 31 +++
 rtl/axi_wr_sched.sv | 110 +++++++++++
 2 files changed

// File: rtl/axi_sched_pkg.sv
// Shared types and round-robin helper for the AXI write-channel scheduler.
package axi_sched_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam int unsigned RR_MAX = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_res_t;

    // Scans n requesters starting just past 'last', wrapping; the final probe is 'last' itself.
    function automatic rr_res_t rr_pick(input logic [RR_MAX-1:0] req,
                                        input logic [3:0]        last,
                                        input logic              lsb_high,
                                        input int unsigned       n);
        rr_res_t     res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 1; k <= n; k++) begin
            idx = lsb_high ? (int'(last) + k) % n : (int'(last) + n - k) % n;
            if (!res.found && req[idx[3:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[3:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_wr_sched.sv
// Round-robin transaction scheduler sharing one downstream AXI write channel
// (AW/W/B) between S_COUNT upstream masters.
module axi_wr_sched
    import axi_sched_pkg::*;
#(
    parameter int S_COUNT           = 4,
    parameter int AW_WIDTH          = 40,
    parameter int W_WIDTH           = 36,
    parameter int B_WIDTH           = 6,
    parameter int LSB_HIGH_PRIORITY = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [S_COUNT*AW_WIDTH-1:0] s_aw_payload,
    input  logic [S_COUNT-1:0]          s_aw_valid,
    output logic [S_COUNT-1:0]          s_aw_ready,
    input  logic [S_COUNT*W_WIDTH-1:0]  s_w_payload,
    input  logic [S_COUNT-1:0]          s_w_last,
    input  logic [S_COUNT-1:0]          s_w_valid,
    output logic [S_COUNT-1:0]          s_w_ready,
    output logic [B_WIDTH-1:0]          s_b_payload,
    output logic [S_COUNT-1:0]          s_b_valid,
    input  logic [S_COUNT-1:0]          s_b_ready,
    output logic [AW_WIDTH-1:0]         m_aw_payload,
    output logic                        m_aw_valid,
    input  logic                        m_aw_ready,
    output logic [W_WIDTH-1:0]          m_w_payload,
    output logic                        m_w_last,
    output logic                        m_w_valid,
    input  logic                        m_w_ready,
    input  logic [B_WIDTH-1:0]          m_b_payload,
    input  logic                        m_b_valid,
    output logic                        m_b_ready,
    output logic                        busy,
    output logic [$clog2(S_COUNT)-1:0]  grant_index
);

    localparam int          IW = $clog2(S_COUNT);
    localparam int unsigned N  = S_COUNT;

    state_t              state, state_next;
    logic [IW-1:0]       grant, last_grant;
    logic [RR_MAX-1:0]   req_ext;
    logic [3:0]          last_ext;
    rr_res_t             pick;

    always_comb begin
        req_ext              = '0;
        req_ext[S_COUNT-1:0] = s_aw_valid;
        last_ext             = '0;
        last_ext[IW-1:0]     = last_grant;
        pick = rr_pick(req_ext, last_ext, LSB_HIGH_PRIORITY != 0, N);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= IW'(S_COUNT - 1);
            m_aw_payload <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick.found) begin
                grant        <= pick.idx[IW-1:0];
                m_aw_payload <= s_aw_payload[int'(pick.idx)*AW_WIDTH +: AW_WIDTH];
            end
            if (state == RESP && m_b_valid && s_b_ready[grant])
                last_grant <= grant;
        end
    end

    always_comb begin
        state_next  = state;
        s_aw_ready  = '0;
        s_w_ready   = '0;
        s_b_valid   = '0;
        s_b_payload = '0;
        m_aw_valid  = 1'b0;
        m_w_payload = '0;
        m_w_last    = 1'b0;
        m_w_valid   = 1'b0;
        m_b_ready   = 1'b0;
        busy        = (state != IDLE);
        grant_index = (state == IDLE) ? last_grant : grant;
        case (state)
            IDLE: if (pick.found) state_next = ADDR;
            ADDR: begin
                m_aw_valid        = 1'b1;
                s_aw_ready[grant] = m_aw_ready;
                if (m_aw_ready) state_next = DATA;
            end
            DATA: begin
                m_w_valid        = s_w_valid[grant];
                m_w_last         = s_w_last[grant];
                m_w_payload      = s_w_valid[grant] ?
                                   s_w_payload[int'(grant)*W_WIDTH +: W_WIDTH] : '0;
                s_w_ready[grant] = m_w_ready;
                if (s_w_valid[grant] && m_w_ready && s_w_last[grant]) state_next = RESP;
            end
            RESP: begin
                s_b_valid[grant] = m_b_valid;
                m_b_ready        = s_b_ready[grant];
                s_b_payload      = m_b_valid ? m_b_payload : '0;
                if (m_b_valid && s_b_ready[grant]) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
